rotr_seq: RTL and testbench

Multi-cycle 16-bit rotate-right unit for the execute stage; the right-rotate counterpart to the existing combinational rotate-left stages. It accepts an operand and a 4-bit rotate amount with a start pulse. It applies the rotation as four conditional stages (by 1, 2, 4 and 8), one stage per clock. It then signals completion with a one-cycle done pulse and holds the result.

---
 rtl/rotr_seq_if.sv | 11 +
 rtl/rotr_seq.sv | 54 +++++
 tb/tb_rotr_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/rotr_seq_if.sv
// rotr_seq_if: start/operand/result handshake bundle for the rotate-right unit.
interface rotr_seq_if;
  logic        start_i;
  logic [15:0] in_i;
  logic [3:0]  cnt_i;
  logic [15:0] out_o;
  logic        busy_o;
  logic        done_o;
  modport master (output start_i, in_i, cnt_i, input out_o, busy_o, done_o);
  modport slave  (input start_i, in_i, cnt_i, output out_o, busy_o, done_o);
endinterface

// File: rtl/rotr_seq.sv
// rotr_seq: 16-bit rotate-right, one conditional stage (1,2,4,8) per clock.
module rotr_seq (
  input logic       clk,
  input logic       rst,
  rotr_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, R1, R2, R4, R8, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] out_q, out_d;
  logic [3:0]  amt_q, amt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      amt_q   <= amt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    amt_d   = amt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = bus.start_i ? R1 : IDLE;
        out_d   = bus.start_i ? bus.in_i : out_q;
        amt_d   = bus.start_i ? bus.cnt_i : amt_q;
      end
      R1: begin
        out_d   = amt_q[0] ? {out_q[0], out_q[15:1]} : out_q;
        state_d = R2;
      end
      R2: begin
        out_d   = amt_q[1] ? {out_q[1:0], out_q[15:2]} : out_q;
        state_d = R4;
      end
      R4: begin
        out_d   = amt_q[2] ? {out_q[3:0], out_q[15:4]} : out_q;
        state_d = R8;
      end
      R8: begin
        out_d   = amt_q[3] ? {out_q[7:0], out_q[15:8]} : out_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.out_o  = out_q;
  assign bus.busy_o = (state_q == R1) || (state_q == R2) || (state_q == R4) || (state_q == R8);
  assign bus.done_o = (state_q == DONE);
endmodule

// File: tb/tb_rotr_seq.sv
// tb_rotr_seq: directed plus random checks against a doubled-word rotate model.
module tb_rotr_seq;
  logic clk = 0;
  logic rst = 1;
  int   n_chk = 0;
  int   n_fail = 0;
  rotr_seq_if bus ();
  rotr_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] rotr_m(input logic [15:0] x, input int k);
    logic [31:0] w;
    w = {x, x} >> k;
    return w[15:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [15:0] d, input logic [3:0] c);
    int lat;
    bus.start_i = 1;
    bus.in_i    = d;
    bus.cnt_i   = c;
    tick();
    bus.start_i = 0;
    bus.in_i    = 16'($urandom);
    bus.cnt_i   = 4'($urandom);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      lat = i;
      if (bus.done_o) break;
      chk("busy_run", 32'(bus.busy_o), 1);
    end
    chk("latency", lat, 4);
    chk("result", 32'(bus.out_o), 32'(rotr_m(d, int'(c))));
    tick();
    chk("done_drop", 32'(bus.done_o), 0);
    chk("out_hold", 32'(bus.out_o), 32'(rotr_m(d, int'(c))));
  endtask
  initial begin
    bus.start_i = 1;
    bus.in_i    = 16'hFFFF;
    bus.cnt_i   = 4'd3;
    tick();
    tick();
    chk("rst_out", 32'(bus.out_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    bus.start_i = 0;
    rst = 0;
    tick();
    tick();
    chk("idle_busy", 32'(bus.busy_o), 0);
    chk("idle_out", 32'(bus.out_o), 0);
    run_op(16'h1234, 4'd4);
    run_op(16'h1234, 4'd8);
    run_op(16'h8001, 4'd1);
    run_op(16'h0001, 4'd15);
    run_op(16'hA5C3, 4'd0);
    // second start lands in R2 and must be ignored
    bus.start_i = 1; bus.in_i = 16'h00F0; bus.cnt_i = 4'd4;
    tick();
    bus.start_i = 0;
    tick();
    bus.start_i = 1; bus.in_i = 16'hFFFF; bus.cnt_i = 4'd1;
    tick();
    bus.start_i = 0;
    chk("ign_busy", 32'(bus.busy_o), 1);
    tick();
    tick();
    chk("ign_done", 32'(bus.done_o), 1);
    chk("ign_out", 32'(bus.out_o), 16'h000F);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_no2nd", 32'(bus.done_o), 0);
    end
    bus.start_i = 1; bus.in_i = 16'h0003; bus.cnt_i = 4'd1;
    tick();
    repeat (3) tick();
    tick();
    chk("b2b_done1", 32'(bus.done_o), 1);
    chk("b2b_out1", 32'(bus.out_o), 16'h8001);
    bus.in_i = 16'h1000; bus.cnt_i = 4'd12;
    repeat (4) tick();
    chk("b2b_busy2", 32'(bus.busy_o), 1);
    tick();
    chk("b2b_done2", 32'(bus.done_o), 1);
    chk("b2b_out2", 32'(bus.out_o), 16'h0001);
    bus.start_i = 0;
    tick();
    chk("b2b_idle", 32'(bus.done_o | bus.busy_o), 0);
    bus.start_i = 1; bus.in_i = 16'h1234; bus.cnt_i = 4'd4;
    tick();
    bus.start_i = 0;
    tick();
    tick();
    rst = 1;
    tick();
    chk("mid_rst_out", 32'(bus.out_o), 0);
    chk("mid_rst_busy", 32'(bus.busy_o), 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_nodone", 32'(bus.done_o), 0);
    end
    for (int i = 0; i < 20; i++) run_op(16'($urandom), 4'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
